// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data RAM.
// Each access takes IDLE -> ACCESS -> RESP, so a new grant is possible every third cycle.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rd_data,
  output logic          cs_ram,
  output logic          wr_ram,
  output logic [AW-1:0] addr_ram,
  output logic [DW-1:0] wdata_ram,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic          we_q, we_d;
  logic          cs_q, cs_d;
  logic          wr_q, wr_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          elig0, elig1, pick;

  // A requester whose ack is showing this cycle is still holding req; it must not be re-granted.
  always_comb begin
    elig0        = req0 & ~ack0_q;
    elig1        = req1 & ~ack1_q;
    pick         = (elig0 & elig1) ? ~last_grant_q : elig1;

    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_data_d    = rd_data_q;
    cs_d         = 1'b0;
    wr_d         = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (elig0 | elig1) begin
          grant_d = pick;
          we_d    = pick ? we1 : we0;
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          cs_d    = 1'b1;
          wr_d    = pick ? we1 : we0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
      end
      RESP: begin
        if (!we_q) begin
          rd_data_d = ram_rdata;
        end
        ack0_d       = ~grant_q;
        ack1_d       = grant_q;
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      cs_q         <= 1'b0;
      wr_q         <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      cs_q         <= cs_d;
      wr_q         <= wr_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // The ack cycle still belongs to the transaction, giving busy its three-cycle span.
  assign busy      = (state_q != IDLE) | ack0_q | ack1_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rd_data   = rd_data_q;
  assign cs_ram    = cs_q;
  assign wr_ram    = wr_q;
  assign addr_ram  = addr_q;
  assign wdata_ram = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a RAM model, a transaction-level arbitration model feeding
// expected RAM accesses and acks into queues, and a negedge monitor that scores the DUT.
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rd_data;
  logic          cs_ram, wr_ram;
  logic [AW-1:0] addr_ram;
  logic [DW-1:0] wdata_ram;
  logic [DW-1:0] ram_rdata;
  logic          busy;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rd_data(rd_data),
    .cs_ram(cs_ram), .wr_ram(wr_ram), .addr_ram(addr_ram), .wdata_ram(wdata_ram),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    bit            who;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  int            tests = 0;
  int            failed = 0;
  int            cyc = 0;
  bit            armed = 1'b0;
  txn_t          cs_q[$];
  txn_t          ack_q[$];
  logic [DW-1:0] ram[256];
  logic [DW-1:0] ref_mem[256];
  logic [DW-1:0] last_rd;
  bit            m_last;
  int            m_free, m_busy_lo, m_busy_hi;
  txn_t          m_e;
  bit            exp_cs, exp_ack, exp_a0, exp_a1, exp_busy, e0, e1, pick;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      failed++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit who, input logic r, input logic w,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!who) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic wait_ack(input bit who);
    bit seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((!who && ack0) || (who && ack1)) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(who ? "ack1_seen" : "ack0_seen", seen, 1);
  endtask

  // One complete request: raise, hold until ack, drop on the following edge.
  task automatic do_req(input bit who, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    applyStimulus(who, 1'b1, w, a, d);
    wait_ack(who);
    tick();
    applyStimulus(who, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic rand_driver(input bit who);
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      do_req(who, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
    end
  endtask

  // The RAM: registered read data, visible the cycle after it sees cs_ram with wr_ram low.
  always @(posedge clk) begin
    if (cs_ram) begin
      if (wr_ram) ram[addr_ram] <= wdata_ram;
      else        ram_rdata <= ram[addr_ram];
    end
  end

  // Monitor first scores this cycle's outputs, then the model decides the coming edge.
  always @(negedge clk) begin
    cyc++;
    exp_cs = 1'b0; exp_ack = 1'b0; exp_a0 = 1'b0; exp_a1 = 1'b0;
    if (armed) begin
      exp_cs = cs_q.size() > 0 && cs_q[0].cyc == cyc;
      if (cs_ram || wr_ram || exp_cs) begin
        checkOutput("cs_ram", cs_ram, exp_cs);
        if (exp_cs) begin
          m_e = cs_q.pop_front();
          checkOutput("wr_ram", wr_ram, m_e.we);
          checkOutput("addr_ram", addr_ram, m_e.addr);
          checkOutput("wdata_ram", wdata_ram, m_e.wdata);
        end else begin
          checkOutput("wr_ram_idle", wr_ram, 0);
        end
      end
      exp_ack = ack_q.size() > 0 && ack_q[0].cyc == cyc;
      exp_a0  = exp_ack && !ack_q[0].who;
      exp_a1  = exp_ack && ack_q[0].who;
      if (ack0 || ack1 || exp_ack) begin
        checkOutput("ack0", ack0, exp_a0);
        checkOutput("ack1", ack1, exp_a1);
        if (exp_ack) begin
          m_e = ack_q.pop_front();
          if (m_e.we) begin
            ref_mem[m_e.addr] = m_e.wdata;
            checkOutput("rd_data_hold", rd_data, last_rd);
          end else begin
            last_rd = ref_mem[m_e.addr];
            checkOutput("rd_data", rd_data, last_rd);
          end
        end
      end
      exp_busy = cyc >= m_busy_lo && cyc <= m_busy_hi;
      if (busy || exp_busy) checkOutput("busy", busy, exp_busy);
    end

    if (rst) begin
      // An aborted write still reached the RAM if its chip-select cycle has already passed.
      foreach (ack_q[i]) begin
        if (ack_q[i].we && ack_q[i].cyc - 2 <= cyc) ref_mem[ack_q[i].addr] = ack_q[i].wdata;
      end
      cs_q.delete();
      ack_q.delete();
      last_rd   = '0;
      m_last    = 1'b1;
      m_free    = cyc + 1;
      m_busy_lo = 0;
      m_busy_hi = cyc;
      armed     = 1'b1;
    end else if (armed && cyc >= m_free) begin
      e0 = req0 && !exp_a0;
      e1 = req1 && !exp_a1;
      if (e0 || e1) begin
        pick      = (e0 && e1) ? !m_last : e1;
        m_e.who   = pick;
        m_e.we    = pick ? we1 : we0;
        m_e.addr  = pick ? addr1 : addr0;
        m_e.wdata = pick ? wdata1 : wdata0;
        m_e.cyc   = cyc + 1;
        cs_q.push_back(m_e);
        m_e.cyc   = cyc + 3;
        ack_q.push_back(m_e);
        m_last    = pick;
        m_free    = cyc + 3;
        m_busy_lo = cyc + 1;
        m_busy_hi = cyc + 3;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit cs_seen;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = DW'(16'h1000 + i * 3);
      ref_mem[i] = DW'(16'h1000 + i * 3);
    end
    ram_rdata = '0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);

    @(negedge clk);
    checkOutput("rst_cs_ram", cs_ram, 0);
    checkOutput("rst_wr_ram", wr_ram, 0);
    checkOutput("rst_ack0", ack0, 0);
    checkOutput("rst_ack1", ack1, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_addr_ram", addr_ram, 0);
    checkOutput("rst_wdata_ram", wdata_ram, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    tick();
    rst = 1'b0;
    tick();

    // Single write then single read of the same location.
    do_req(1'b0, 1'b1, 8'h10, 16'hA5A5);
    tick();
    do_req(1'b1, 1'b0, 8'h10, 16'h0000);
    tick();

    // Both requesters held high: grants must alternate.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h05, 16'h5555);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h05, 16'h0000);
    repeat (12) tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (5) tick();

    // Request withdrawn right after its grant must still be acknowledged.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h20, 16'h0000);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    wait_ack(1'b0);
    repeat (4) tick();

    // Reset while the access is in flight, then a tie that must go to requester 0.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h30, 16'h1234);
    cs_seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cs_ram) begin
        cs_seen = 1'b1;
        break;
      end
    end
    checkOutput("cs_seen_before_rst", cs_seen, 1);
    tick();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    rst = 1'b0;
    tick();
    fork
      do_req(1'b0, 1'b0, 8'h30, 16'h0000);
      do_req(1'b1, 1'b0, 8'h31, 16'h0000);
    join
    repeat (3) tick();

    fork
      rand_driver(1'b0);
      rand_driver(1'b1);
    join
    repeat (6) tick();

    checkOutput("queues_drained", cs_q.size() + ack_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
